// File: rtl/meas_window_ctrl.sv
// Measurement-window controller: arms on start, tracks min/max/peaks/flat runs over
// the ADC stream, closes on peak count, DC run or sample timeout, then holds amp/mean.
module meas_window_ctrl #(
  parameter int DATA_W      = 12,
  parameter int PEAK_LIMIT  = 10,
  parameter int DC_LIMIT    = 100,
  parameter int MAX_SAMPLES = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_continuous,
  input  logic              i_abort,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_busy,
  output logic              o_result_valid,
  input  logic              i_result_ack,
  output logic [DATA_W-1:0] o_amp,
  output logic [DATA_W-1:0] o_mean,
  output logic [DATA_W-1:0] o_max_val,
  output logic [DATA_W-1:0] o_min_val,
  output logic [7:0]        o_peaks,
  output logic              o_dc_flag,
  output logic              o_timeout_flag
);

  localparam int DCW = $clog2(DC_LIMIT + 1);
  localparam int CW  = $clog2(MAX_SAMPLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACQ, S_CALC, S_DONE} state_t;
  typedef enum logic [1:0] {SL_NONE, SL_RISE, SL_FALL} slope_t;

  state_t            r_state;
  slope_t            r_slope_prev;
  logic [DATA_W-1:0] r_run_min;
  logic [DATA_W-1:0] r_run_max;
  logic [DATA_W-1:0] r_prev;
  logic [7:0]        r_peaks;
  logic [DCW-1:0]    r_dc_run;
  logic [CW-1:0]     r_sample_cnt;
  logic              r_dc_hit;
  logic              r_to_hit;

  logic              r_busy;
  logic              r_result_valid;
  logic [DATA_W-1:0] r_amp;
  logic [DATA_W-1:0] r_mean;
  logic [DATA_W-1:0] r_max_val;
  logic [DATA_W-1:0] r_min_val;
  logic [7:0]        r_peaks_out;
  logic              r_dc_flag;
  logic              r_timeout_flag;

  // Per-sample next values for the ACQ state
  logic              w_rise;
  logic              w_fall;
  logic              w_peak;
  logic [7:0]        w_peaks_nxt;
  logic [DCW-1:0]    w_dc_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [DATA_W-1:0] w_min_nxt;
  logic [DATA_W-1:0] w_max_nxt;
  logic              w_pk_hit;
  logic              w_dc_hit;
  logic              w_to_hit;
  logic              w_close;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W:0]   w_sum;

  always_comb begin
    w_rise      = i_data_in > r_prev;
    w_fall      = i_data_in < r_prev;
    w_peak      = w_fall && (r_slope_prev == SL_RISE);
    w_peaks_nxt = (w_peak && (r_peaks != 8'hFF)) ? r_peaks + 8'd1 : r_peaks;
    w_dc_nxt    = (w_rise || w_fall) ? '0 : r_dc_run + DCW'(1);
    w_cnt_nxt   = r_sample_cnt + CW'(1);
    w_min_nxt   = (i_data_in <= r_run_min) ? i_data_in : r_run_min;
    w_max_nxt   = (i_data_in >= r_run_max) ? i_data_in : r_run_max;
    // Close conditions use the counts that include the current sample
    w_pk_hit    = ({24'd0, w_peaks_nxt} == 32'(PEAK_LIMIT));
    w_dc_hit    = (w_dc_nxt == DCW'(DC_LIMIT));
    w_to_hit    = (w_cnt_nxt == CW'(MAX_SAMPLES));
    w_close     = w_pk_hit || w_dc_hit || w_to_hit;
    w_diff      = r_run_max - r_run_min;
    w_sum       = {1'b0, r_run_max} + {1'b0, r_run_min};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_slope_prev   <= SL_NONE;
      r_run_min      <= '1;
      r_run_max      <= '0;
      r_prev         <= '0;
      r_peaks        <= '0;
      r_dc_run       <= '0;
      r_sample_cnt   <= '0;
      r_dc_hit       <= 1'b0;
      r_to_hit       <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_amp          <= '0;
      r_mean         <= '0;
      r_max_val      <= '0;
      r_min_val      <= '0;
      r_peaks_out    <= '0;
      r_dc_flag      <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else if (i_abort) begin
      // Abort keeps the last published result but withdraws its valid
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_ARM;
            r_busy  <= 1'b1;
          end
        end
        S_ARM: begin
          if (i_sample_valid) begin
            r_run_min    <= i_data_in;
            r_run_max    <= i_data_in;
            r_prev       <= i_data_in;
            r_slope_prev <= SL_NONE;
            r_peaks      <= '0;
            r_dc_run     <= '0;
            r_sample_cnt <= CW'(1);
            r_state      <= S_ACQ;
          end
        end
        S_ACQ: begin
          if (i_sample_valid) begin
            r_run_min    <= w_min_nxt;
            r_run_max    <= w_max_nxt;
            r_prev       <= i_data_in;
            r_peaks      <= w_peaks_nxt;
            r_dc_run     <= w_dc_nxt;
            r_sample_cnt <= w_cnt_nxt;
            // Flat steps leave slope history alone so plateau tops still count
            if (w_rise)      r_slope_prev <= SL_RISE;
            else if (w_fall) r_slope_prev <= SL_FALL;
            if (w_close) begin
              r_dc_hit <= w_dc_hit;
              r_to_hit <= w_to_hit;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_amp          <= {1'b0, w_diff[DATA_W-1:1]};
          r_mean         <= w_sum[DATA_W:1];
          r_max_val      <= r_run_max;
          r_min_val      <= r_run_min;
          r_peaks_out    <= r_peaks;
          r_dc_flag      <= r_dc_hit;
          r_timeout_flag <= r_to_hit;
          r_result_valid <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= S_DONE;
        end
        S_DONE: begin
          if (i_result_ack) begin
            r_result_valid <= 1'b0;
            if (i_continuous) begin
              r_state <= S_ARM;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_result_valid = r_result_valid;
  assign o_amp          = r_amp;
  assign o_mean         = r_mean;
  assign o_max_val      = r_max_val;
  assign o_min_val      = r_min_val;
  assign o_peaks        = r_peaks_out;
  assign o_dc_flag      = r_dc_flag;
  assign o_timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_meas_window_ctrl.sv
// Scoreboard bench for meas_window_ctrl: stimulus pushes expected results with their
// due cycle, per-instance monitors pop and compare on each result_valid rise.
module tb_meas_window_ctrl;

  typedef struct {
    int amp;
    int mean;
    int mx;
    int mn;
    int pk;
    int dc;
    int to;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        cont = 1'b0, abort_s = 1'b0;
  logic        sv = 1'b0;
  logic [11:0] din = '0;
  logic        ack_a = 1'b0, ack_b = 1'b0;

  logic        a_busy, a_rv, a_dc, a_to;
  logic [11:0] a_amp, a_mean, a_max, a_min;
  logic [7:0]  a_pk;
  logic        b_busy, b_rv, b_dc, b_to;
  logic [11:0] b_amp, b_mean, b_max, b_min;
  logic [7:0]  b_pk;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rva_q = 1'b0, rvb_q = 1'b0;

  meas_window_ctrl #(.DATA_W(12), .PEAK_LIMIT(3), .DC_LIMIT(4), .MAX_SAMPLES(4096)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_continuous(cont), .i_abort(abort_s),
    .i_sample_valid(sv), .i_data_in(din), .o_busy(a_busy), .o_result_valid(a_rv),
    .i_result_ack(ack_a), .o_amp(a_amp), .o_mean(a_mean), .o_max_val(a_max),
    .o_min_val(a_min), .o_peaks(a_pk), .o_dc_flag(a_dc), .o_timeout_flag(a_to));

  meas_window_ctrl #(.DATA_W(12), .PEAK_LIMIT(3), .DC_LIMIT(4), .MAX_SAMPLES(16)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_continuous(cont), .i_abort(abort_s),
    .i_sample_valid(sv), .i_data_in(din), .o_busy(b_busy), .o_result_valid(b_rv),
    .i_result_ack(ack_b), .o_amp(b_amp), .o_mean(b_mean), .o_max_val(b_max),
    .o_min_val(b_min), .o_peaks(b_pk), .o_dc_flag(b_dc), .o_timeout_flag(b_to));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input int amp, mean, mx, mn, pk, dc, to, c);
    exp_t e;
    e.amp = amp; e.mean = mean; e.mx = mx; e.mn = mn;
    e.pk = pk; e.dc = dc; e.to = to; e.cyc = c;
    return e;
  endfunction

  task automatic cmp(input string t, input exp_t e, input int amp, mean, mx, mn, pk, dc, to);
    chk({t, "_latency"}, cyc, e.cyc);
    chk({t, "_amp"}, amp, e.amp);
    chk({t, "_mean"}, mean, e.mean);
    chk({t, "_max"}, mx, e.mx);
    chk({t, "_min"}, mn, e.mn);
    chk({t, "_peaks"}, pk, e.pk);
    chk({t, "_dc_flag"}, dc, e.dc);
    chk({t, "_timeout_flag"}, to, e.to);
  endtask

  always @(negedge clk) begin
    if (a_rv && !rva_q) begin
      if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
      else cmp("a", qa.pop_front(), a_amp, a_mean, a_max, a_min, a_pk, a_dc, a_to);
    end
    rva_q <= a_rv;
  end

  always @(negedge clk) begin
    if (b_rv && !rvb_q) begin
      if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
      else cmp("b", qb.pop_front(), b_amp, b_mean, b_max, b_min, b_pk, b_dc, b_to);
    end
    rvb_q <= b_rv;
  end

  function automatic int tri_v(input int i);
    int p;
    p = i % 58;
    return (p <= 29) ? 100 + 100 * p : 100 + 100 * (58 - p);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    sv = 1'b1;
    din = 12'(v);
    step();
  endtask

  task automatic go_a();
    start_a = 1'b1; step(); start_a = 1'b0;
  endtask

  task automatic wait_rv_a(input string nm);
    int n;
    n = 0;
    while (!a_rv && n < 10) begin step(); n++; end
    chk(nm, a_rv, 1);
  endtask

  task automatic do_ack_a();
    ack_a = 1'b1; step(); ack_a = 1'b0;
  endtask

  // Triangle 100->3000->100...: third peak is the falling sample at index 146
  task automatic run_triangle(input string nm);
    go_a();
    chk({nm, "_busy"}, a_busy, 1);
    for (int i = 0; i < 147; i++) send(tri_v(i));
    qa.push_back(mk(1450, 1550, 3000, 100, 3, 0, 0, cyc + 1));
    sv = 1'b0;
    wait_rv_a({nm, "_rv"});
    do_ack_a();
    chk({nm, "_idle_after_ack"}, a_busy, 0);
    chk({nm, "_rv_after_ack"}, a_rv, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_amp", a_amp, 0);
    chk("rst_mean", a_mean, 0);
    chk("rst_max", a_max, 0);
    chk("rst_min", a_min, 0);
    chk("rst_peaks", a_pk, 0);
    chk("rst_flags", {a_dc, a_to}, 0);
    rst = 1'b0;
    step();

    run_triangle("tri1");

    // Flat 2048: arming sample plus 4 flat steps closes on dc
    go_a();
    for (int i = 0; i < 5; i++) send(2048);
    qa.push_back(mk(0, 2048, 2048, 2048, 0, 1, 0, cyc + 1));
    sv = 1'b0;
    wait_rv_a("dc_rv");
    do_ack_a();

    // Ramp on the MAX_SAMPLES=16 instance closes on value 15
    start_b = 1'b1; step(); start_b = 1'b0;
    chk("b_busy", b_busy, 1);
    for (int i = 0; i < 16; i++) send(i);
    qb.push_back(mk(7, 7, 15, 0, 0, 0, 1, cyc + 1));
    sv = 1'b0;
    step(); step();
    chk("b_rv", b_rv, 1);
    ack_b = 1'b1; step(); ack_b = 1'b0;
    chk("b_idle", b_busy, 0);

    // start with abort in IDLE stays idle
    start_a = 1'b1; abort_s = 1'b1; step(); start_a = 1'b0; abort_s = 1'b0;
    chk("start_abort_busy", a_busy, 0);

    // Abort mid-window keeps old outputs and no valid
    go_a();
    for (int i = 0; i < 5; i++) send(tri_v(i));
    sv = 1'b0;
    abort_s = 1'b1; step(); abort_s = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_rv", a_rv, 0);
    chk("abort_amp_kept", a_amp, 0);
    chk("abort_mean_kept", a_mean, 2048);
    chk("abort_dc_kept", a_dc, 1);
    run_triangle("tri2");

    // Continuous with ack held off: samples in DONE are ignored
    cont = 1'b1;
    go_a();
    for (int i = 0; i < 5; i++) send(500);
    qa.push_back(mk(0, 500, 500, 500, 0, 1, 0, cyc + 1));
    sv = 1'b0;
    wait_rv_a("cont1_rv");
    for (int k = 0; k < 20; k++) send(3000 - k * 37);
    sv = 1'b0;
    chk("holdoff_rv", a_rv, 1);
    chk("holdoff_mean", a_mean, 500);
    chk("holdoff_max", a_max, 500);
    do_ack_a();
    chk("rearm_busy", a_busy, 1);
    chk("rearm_rv", a_rv, 0);
    for (int i = 0; i < 5; i++) send(1000);
    qa.push_back(mk(0, 1000, 1000, 1000, 0, 1, 0, cyc + 1));
    sv = 1'b0;
    wait_rv_a("cont2_rv");
    cont = 1'b0;
    do_ack_a();
    chk("cont_end_busy", a_busy, 0);

    // Async reset between edges mid-ACQ
    go_a();
    send(1500); send(1600); send(1700);
    sv = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", a_busy, 0);
    chk("arst_rv", a_rv, 0);
    chk("arst_mean", a_mean, 0);
    chk("arst_max", a_max, 0);
    chk("arst_dc", a_dc, 0);
    chk("arst_b_timeout", b_to, 0);
    #2 rst = 1'b0;
    step();
    for (int i = 0; i < 5; i++) send(2048);
    sv = 1'b0;
    step(); step();
    chk("arst_nostart_busy", a_busy, 0);
    chk("arst_nostart_rv", a_rv, 0);
    go_a();
    for (int i = 0; i < 5; i++) send(777);
    qa.push_back(mk(0, 777, 777, 777, 0, 1, 0, cyc + 1));
    sv = 1'b0;
    wait_rv_a("post_rst_rv");
    do_ack_a();

    step(); step();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/meas_window_ctrl.md
# meas_window_ctrl

Measurement-window controller for the oscilloscope front end. It sequences one amplitude/mean measurement over the ADC sample stream: it arms on command, tracks running min/max and slope over a bounded window, and closes the window on a peak count, a flat (DC) run or a sample timeout. It then computes amplitude and mean and holds the result under a valid/ack handshake. It sits between the ADC sample register and the display/readout logic, and supports one-shot and continuous re-arm.

## Interface
- DATA_W, 12, sample width
- PEAK_LIMIT, 10, detected peaks that close the window (≥1)
- DC_LIMIT, 100, consecutive equal-sample steps that close the window (≥1)
- MAX_SAMPLES, 4096, accepted samples (including the arming sample) that close the window (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a measurement; honoured only in IDLE
- continuous  in  1  after ack, re-arm instead of returning to IDLE; sampled at ack
- abort  in  1  return to IDLE from any state
- sample_valid  in  1  data_in carries a new sample this cycle
- data_in  in  DATA_W  ADC sample, unsigned
- busy  out  1  high in ARM, ACQ, CALC
- result_valid  out  1  result registers hold a fresh measurement
- result_ack  in  1  consumer takes result; honoured only while result_valid
- amp  out  DATA_W  (max−min)>>1
- mean  out  DATA_W  (max+min)>>1, sum carried at DATA_W+1 bits
- max_val, min_val  out  DATA_W  window extremes
- peaks  out  8  peaks counted in the window
- dc_flag, timeout_flag  out  1  window-close cause(s)

## Operation
- States: IDLE, ARM, ACQ, CALC, DONE.
- IDLE: start → ARM. Other inputs except abort are ignored.
- ARM: first sample_valid loads run_min=run_max=prev=data_in, sets slope_prev=NONE, sets peaks=0 and dc_run=0, sets sample_cnt=1 → ACQ.
- ACQ, per valid sample:
  - min/max: update on ≤ and ≥.
  - slope: RISE if data_in>prev; FALL if data_in<prev; FLAT if equal.
  - peak: slope=FALL and slope_prev=RISE. Increment peaks, saturating at 255.
  - slope_prev: updated only on RISE or FALL, so plateau tops still count as peaks.
  - dc_run: increments on FLAT, clears on RISE or FALL.
  - sample_cnt: increments.
  - prev: takes data_in.
- Close conditions, evaluated using post-update counts of the same sample:
  - peaks==PEAK_LIMIT
  - dc_run==DC_LIMIT
  - sample_cnt==MAX_SAMPLES
  - Any true → CALC. dc_flag and timeout_flag capture their conditions; more than one may be set.
- Cycles without sample_valid change nothing.
- CALC (one cycle):
  - Write amp, mean, max_val, min_val, peaks and both flags to the output registers.
  - Set result_valid → DONE.
- DONE: result_ack clears result_valid. Then continuous=1 → ARM, continuous=0 → IDLE. Samples arriving in DONE are dropped.
- abort (highest priority, any state) → IDLE and clears result_valid. Output result registers are retained.
- start outside IDLE is ignored. Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- Reset values: state IDLE; busy, result_valid, dc_flag and timeout_flag 0; amp, mean, max_val, min_val and peaks 0. Internal trackers: run_min = all ones, run_max = 0.

## Timing
- start registered at edge S → ARM (busy=1) after S. The earliest sample accepted is at edge S+1.
- Closing sample captured at edge T → CALC. Outputs and result_valid are updated at edge T+1, so minimum result latency is 2 edges.
- result_ack seen at edge A with result_valid=1: result_valid=0 after A. With continuous, ARM after A and the next sample is accepted at A+1.
- Results are stable from T+1 until the next CALC.
- Reset asserted mid-window clears everything immediately, independent of clk.

## Test plan
- PEAK_LIMIT=3, triangle 100→3000→100 in steps of 100, one sample per cycle → result_valid 2 edges after the 3rd peak's first falling sample; amp=1450, mean=1550, peaks=3, flags 0.
- DC_LIMIT=4, data_in constant 2048 → closes on the 5th sample; amp=0, mean=2048, dc_flag=1, timeout_flag=0.
- MAX_SAMPLES=16, ramp 0..15 → closes on value 15; amp=7, mean=7, peaks=0, timeout_flag=1.
- abort at sample 5 of a window, then start with a new triangle → result_valid stays 0 until the new window closes. Old outputs remain unchanged until then.
- continuous=1 with ack held off 20 cycles → result_valid stays high and samples are ignored; after ack, ARM, next window result_valid again.
- rst pulsed mid-ACQ between clock edges → outputs read reset values immediately; start is required to resume.
